// File: rtl/mips_pkg.sv
// Shared constants for the MIPS R2000 pipeline blocks.
package mips_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [WORD_W-1:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/instr_mem.sv
// Byte-addressed instruction memory: one synchronous byte write port and a
// combinational little-endian 32-bit read port. Addresses wrap modulo IMEM_BYTES.
module instr_mem
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [WORD_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [WORD_W-1:0] raddr_i,
  output logic [WORD_W-1:0] Read_data
);

  localparam int unsigned AW = $clog2(IMEM_BYTES);

  logic [7:0]    instruction [IMEM_BYTES];
  logic [AW-1:0] widx;
  logic [AW-1:0] ridx;

  // Only the low address bits select a byte; the rest alias by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{waddr_i[WORD_W-1:AW], raddr_i[WORD_W-1:AW]};

  assign widx = waddr_i[AW-1:0];
  assign ridx = raddr_i[AW-1:0];

  // Byte write port; contents are deliberately not cleared by reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      instruction[widx] <= wdata_i;
    end
  end

  // Little-endian word read; each byte index wraps independently at the top.
  always_comb begin
    Read_data = {instruction[ridx + AW'(3)],
                 instruction[ridx + AW'(2)],
                 instruction[ridx + AW'(1)],
                 instruction[ridx]};
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction memory and the IF/ID
// pipeline register, with hazard-unit stalls and ID-stage redirect/flush.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int unsigned       IMEM_BYTES = 1024,
  parameter logic [WORD_W-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pc_write_i,
  input  logic              if_id_write_i,
  input  logic              flush_i,
  input  logic              redirect_i,
  input  logic [WORD_W-1:0] redirect_pc_i,
  input  logic              imem_we_i,
  input  logic [WORD_W-1:0] imem_waddr_i,
  input  logic [7:0]        imem_wdata_i,
  output logic [WORD_W-1:0] pc_o,
  output logic [WORD_W-1:0] if_id_instr_o,
  output logic [WORD_W-1:0] if_id_pc4_o,
  output logic              if_id_valid_o,
  output logic              misaligned_o
);

  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic              mis_q, mis_d;
  logic [WORD_W-1:0] fetch_word;
  logic [WORD_W-1:0] pc_plus4;

  instr_mem #(
    .IMEM_BYTES(IMEM_BYTES)
  ) Instruction_memory (
    .clk_i    (clk_i),
    .we_i     (imem_we_i),
    .waddr_i  (imem_waddr_i),
    .wdata_i  (imem_wdata_i),
    .raddr_i  (pc_q),
    .Read_data(fetch_word)
  );

  assign pc_plus4 = pc_q + PC_STEP;

  // Next-state selection: redirect beats a PC stall, flush beats an IF/ID stall.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    mis_d   = mis_q | (redirect_i & (|redirect_pc_i[1:0]));

    if (redirect_i) begin
      pc_d = {redirect_pc_i[WORD_W-1:2], 2'b00};
    end else if (pc_write_i) begin
      pc_d = pc_plus4;
    end

    if (flush_i) begin
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (if_id_write_i) begin
      instr_d = fetch_word;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_o          = pc_q;
  assign if_id_instr_o = instr_q;
  assign if_id_pc4_o   = pc4_q;
  assign if_id_valid_o = valid_q;
  assign misaligned_o  = mis_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_fetch_stage;

  localparam int unsigned IMEM_BYTES = 1024;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        pc_write;
  logic        if_id_write;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [7:0]  imem_wdata;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        misaligned;

  fetch_stage #(
    .IMEM_BYTES(IMEM_BYTES),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pc_write_i   (pc_write),
    .if_id_write_i(if_id_write),
    .flush_i      (flush),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .imem_we_i    (imem_we),
    .imem_waddr_i (imem_waddr),
    .imem_wdata_i (imem_wdata),
    .pc_o         (pc),
    .if_id_instr_o(if_id_instr),
    .if_id_pc4_o  (if_id_pc4),
    .if_id_valid_o(if_id_valid),
    .misaligned_o (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  logic [7:0]  mem [IMEM_BYTES];
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic        m_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] mword(input logic [31:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] b;
      b = a + 32'(k);
      w[8*k +: 8] = mem[b % IMEM_BYTES];
    end
    return w;
  endfunction

  // Apply one rising edge to the model using the inputs as driven before it.
  task automatic model_edge();
    logic [31:0] fw;
    fw = mword(m_pc);
    if (rst) begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (flush) begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (if_id_write) begin
      m_instr = fw; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
    end
    if (rst)                             m_mis = 1'b0;
    else if (redirect && redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
    if (rst)           m_pc = RESET_PC;
    else if (redirect) m_pc = {redirect_pc[31:2], 2'b00};
    else if (pc_write) m_pc = m_pc + 32'd4;
    if (imem_we) mem[imem_waddr % IMEM_BYTES] = imem_wdata;
  endtask

  // One clock: advance model, then compare every output just after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pc", pc, m_pc);
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_pc4", if_id_pc4, m_pc4);
    check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
    check("misaligned", 32'(misaligned), 32'(m_mis));
  endtask

  task automatic idle();
    rst = 1'b0; pc_write = 1'b1; if_id_write = 1'b1; flush = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; imem_we = 1'b0;
    imem_waddr = 32'h0; imem_wdata = 8'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
    step();
    imem_we = 1'b0;
  endtask

  initial begin
    logic [31:0] old_w;
    idle();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0;

    // Reset for two cycles.
    rst = 1'b1;
    step();
    step();
    check("rst_pc", pc, 32'h0);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_valid", 32'(if_id_valid), 32'h0);
    check("rst_mis", 32'(misaligned), 32'h0);

    // Preload whole memory while reset stays high, then the program bytes.
    for (int i = 0; i < int'(IMEM_BYTES); i++) wr(32'(i), 8'($urandom));
    wr(32'h0, 8'h00); wr(32'h1, 8'h00); wr(32'h2, 8'h42); wr(32'h3, 8'h20);
    wr(32'h4, 8'h01); wr(32'h5, 8'h00); wr(32'h6, 8'h63); wr(32'h7, 8'h20);
    wr(32'h14, 8'h27); wr(32'h15, 8'h38); wr(32'h16, 8'h62); wr(32'h17, 8'h00);

    // Release reset and fetch the first two words.
    rst = 1'b0;
    step();
    check("e1_instr", if_id_instr, 32'h2042_0000);
    check("e1_pc4", if_id_pc4, 32'h4);
    check("e1_pc", pc, 32'h4);
    step();
    check("e2_instr", if_id_instr, 32'h2063_0001);
    check("e2_pc", pc, 32'h8);

    // Two-cycle stall.
    pc_write = 1'b0; if_id_write = 1'b0;
    step();
    step();
    check("stall_pc", pc, 32'h8);
    check("stall_instr", if_id_instr, 32'h2063_0001);
    check("stall_pc4", if_id_pc4, 32'h8);
    pc_write = 1'b1; if_id_write = 1'b1;
    step();
    check("resume_pc", pc, 32'hC);
    check("resume_pc4", if_id_pc4, 32'hC);

    // Redirect plus flush to 0x14.
    redirect = 1'b1; redirect_pc = 32'h14; flush = 1'b1;
    step();
    check("redir_pc", pc, 32'h14);
    check("redir_valid", 32'(if_id_valid), 32'h0);
    check("redir_instr", if_id_instr, 32'h0);
    redirect = 1'b0; flush = 1'b0;
    step();
    check("target_instr", if_id_instr, 32'h0062_3827);
    check("target_pc4", if_id_pc4, 32'h18);

    // Misaligned redirect is sticky until reset.
    redirect = 1'b1; redirect_pc = 32'h16;
    step();
    check("mis_pc", pc, 32'h14);
    check("mis_set", 32'(misaligned), 32'h1);
    redirect = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("mis_sticky", 32'(misaligned), 32'h1);
    end
    rst = 1'b1;
    step();
    check("mis_clear", 32'(misaligned), 32'h0);
    rst = 1'b0;

    // Fetch past the top of memory wraps to byte 0.
    redirect = 1'b1; redirect_pc = 32'h3FC;
    step();
    check("wrap_pc0", pc, 32'h3FC);
    redirect = 1'b0;
    step();
    check("wrap_pc1", pc, 32'h400);
    step();
    check("wrap_instr", if_id_instr, 32'h2042_0000);
    check("wrap_pc4", if_id_pc4, 32'h404);

    // Flush beats an IF/ID stall.
    flush = 1'b1; if_id_write = 1'b0;
    step();
    check("flushstall_instr", if_id_instr, 32'h0);
    check("flushstall_valid", 32'(if_id_valid), 32'h0);
    flush = 1'b0; if_id_write = 1'b1;

    // Redirect beats a PC stall.
    redirect = 1'b1; redirect_pc = 32'h20; pc_write = 1'b0;
    step();
    check("redirstall_pc", pc, 32'h20);
    redirect = 1'b0; pc_write = 1'b1;

    // Writing the byte being fetched: old byte latched, new byte seen later.
    old_w = mword(32'h20);
    imem_we = 1'b1; imem_waddr = 32'h20; imem_wdata = (old_w[7:0] ^ 8'hFF);
    step();
    imem_we = 1'b0;
    check("wr_same_old", if_id_instr, old_w);
    redirect = 1'b1; redirect_pc = 32'h20;
    step();
    redirect = 1'b0;
    step();
    check("wr_same_new", if_id_instr, {old_w[31:8], old_w[7:0] ^ 8'hFF});

    // PC wraps modulo 2^32.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    step();
    check("pc_wrap32", pc, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      pc_write    = ($urandom_range(0, 4) != 0);
      if_id_write = ($urandom_range(0, 4) != 0);
      flush       = ($urandom_range(0, 7) == 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      imem_we     = ($urandom_range(0, 2) == 0);
      imem_waddr  = ($urandom_range(0, 1) == 0) ? $urandom : (m_pc + 32'($urandom_range(0, 3)));
      imem_wdata  = 8'($urandom);
      step();
    end

    idle();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS_R2000 five-stage pipeline. It holds the PC, reads a 32-bit little-endian instruction from a byte-addressed instruction memory, and drives the IF/ID pipeline register consumed by decode. It obeys PCWrite/If_Id_Write stalls from the hazard detection unit, and branch/jump redirect and flush from ID. A byte-wide load port lets the bench preload the program.

## Interface
- IMEM_BYTES, 1024: instruction memory size in bytes; power of two, ≥ 4.
- RESET_PC, 32'h0000_0000: PC value after reset; word-aligned.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- pc_write  in  1  hazard unit PCWrite; 0 holds the PC.
- if_id_write  in  1  hazard unit If_Id_Write; 0 holds IF/ID.
- flush  in  1  squash IF/ID to NOP at the next edge.
- redirect  in  1  load redirect_pc into the PC at the next edge.
- redirect_pc  in  32  branch/jump target.
- imem_we  in  1  instruction-memory byte write enable.
- imem_waddr  in  32  byte address; reduced modulo IMEM_BYTES.
- imem_wdata  in  8  byte data.
- pc  out  32  current fetch PC.
- if_id_instr  out  32  IF/ID instruction.
- if_id_pc4  out  32  IF/ID PC+4.
- if_id_valid  out  1  IF/ID holds a real fetched instruction.
- misaligned  out  1  sticky: a misaligned redirect occurred.

## Operation
- Memory is an array of IMEM_BYTES bytes. A fetch word at address A is {mem[A+3], mem[A+2], mem[A+1], mem[A]}. Each byte index is taken modulo IMEM_BYTES, so a fetch near the top wraps to byte 0.
- Memory read is combinational. Writes take effect at the clock edge.
- Reset does not clear memory. Writes are accepted while rst=1.
- Next-PC priority:
  1. rst → RESET_PC.
  2. redirect → {redirect_pc[31:2], 2'b00}. This overrides pc_write=0.
  3. pc_write=0 → hold.
  4. Otherwise pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- If redirect_pc[1:0] ≠ 0, misaligned is set. It stays set until rst.
- IF/ID priority:
  1. rst or flush → instr=32'h0000_0000 (NOP), pc4=0, valid=0.
  2. if_id_write=0 → hold all three fields.
  3. Otherwise instr=fetch word at pc, pc4=pc+4, valid=1.
- Writing the byte currently being fetched: the old byte is latched into IF/ID this edge. The new byte is visible from the next cycle.

## Timing
- Reset values: pc=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, misaligned=0.
- Fetch latency is one cycle: the instruction at pc appears on if_id_instr after the next rising edge.
- A redirect asserted in cycle N gives pc=target in N+1. That target's instruction appears in IF/ID in N+2.
- A flush in cycle N gives valid=0 in N+1.
- A stall held for k cycles freezes pc and IF/ID for exactly k cycles. Fetch resumes at the same PC with no loss or duplication.
- flush together with if_id_write=0: flush wins.
- redirect together with pc_write=0: redirect wins.

## Structure
- Shared package mips_pkg holds: NOP_INSTR = 32'h0, WORD_W = 32, and PC_STEP = 4.
- One sub-module, instr_mem, contains the byte array, the write port and the little-endian word read. fetch_stage instantiates it as Instruction_memory, with the byte array named instruction and the read port Read_data.

## Test plan
- Reset: hold rst for 2 cycles → pc=0, if_id_instr=0, if_id_valid=0, misaligned=0.
- Preload bytes 00 00 42 20 at 0–3 and 01 00 63 20 at 4–7, then release rst:
  - edge 1 → if_id_instr=0x20420000, if_id_pc4=4, pc=4.
  - edge 2 → if_id_instr=0x20630001, pc=8.
- Stall: with pc=8, drive pc_write=0 and if_id_write=0 for 2 cycles → pc=8 and IF/ID unchanged. After release, the next edge → IF/ID holds the word at 8, pc=0xC.
- Redirect and flush to 0x14, with bytes 27 38 62 00 at 0x14–0x17:
  - N+1 → pc=0x14, if_id_valid=0, if_id_instr=0.
  - N+2 → if_id_instr=0x00623827, if_id_pc4=0x18.
- Misaligned redirect: redirect_pc=0x16 → pc=0x14, misaligned=1. misaligned stays 1 across 10 cycles and clears only after rst.
- Wrap and priority:
  - With IMEM_BYTES=1024, redirect to 0x3FC → pc=0x3FC. Next edge → pc=0x400, and the fetch reads bytes 0–3 (0x20420000).
  - flush with if_id_write=0 → IF/ID becomes NOP with valid=0.
